// File: rtl/bcd_disp_pkg.sv
// Shared constants and helpers for the BCD display counter.
// Seven-segment codes are {g,f,e,d,c,b,a}, active-low.
package bcd_disp_pkg;

  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  function automatic logic [6:0] seg_encode(logic [3:0] v);
    logic [6:0] s;
    case (v)
      4'd0:    s = 7'b1000000;
      4'd1:    s = 7'b1111001;
      4'd2:    s = 7'b0100100;
      4'd3:    s = 7'b0110000;
      4'd4:    s = 7'b0011001;
      4'd5:    s = 7'b0010010;
      4'd6:    s = 7'b0000010;
      4'd7:    s = 7'b1111000;
      4'd8:    s = 7'b0000000;
      4'd9:    s = 7'b0010000;
      default: s = SEG_BLANK;
    endcase
    return s;
  endfunction

  function automatic logic [3:0] bcd_clamp(logic [3:0] v);
    return (v > 4'd9) ? 4'd0 : v;
  endfunction

endpackage

// File: rtl/bcd_display_counter_tick_gen.sv
// Free-running prescaler; tick marks the terminal count,
// which is also the cycle the counter clears.
module tick_gen
  import bcd_disp_pkg::*;
#(
  parameter int DIV = 1
) (
  input  logic clk,
  input  logic rst,
  output logic tick
);

  localparam int W = (DIV > 1) ? $clog2(DIV) : 1;

  logic [W-1:0] cnt;

  assign tick = ~rst & (cnt == W'(DIV - 1));

  always_ff @(posedge clk) begin
    if (rst)       cnt <= '0;
    else if (tick) cnt <= '0;
    else           cnt <= cnt + 1'b1;
  end

endmodule

// File: rtl/bcd_display_counter.sv
// Multi-digit BCD up/down counter with prescaled tick,
// parallel load, wrap flag and multiplexed 7-seg output.
module bcd_display_counter
  import bcd_disp_pkg::*;
#(
  parameter int DIGITS   = 4,
  parameter int CLK_HZ   = 100_000_000,
  parameter int COUNT_HZ = 1,
  parameter int SCAN_HZ  = 1000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic                  up,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   load_val,
  input  logic                  blank_lz,
  output logic [4*DIGITS-1:0]   count,
  output logic                  wrap,
  output logic                  tick,
  output logic [6:0]            seg_cat,
  output logic [DIGITS-1:0]     seg_an
);

  localparam int COUNT_DIV = CLK_HZ / COUNT_HZ;
  localparam int SCAN_DIV  = CLK_HZ / (SCAN_HZ * DIGITS);
  localparam int IW        = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  logic              scan_tick;
  logic [IW-1:0]     idx;
  logic [DIGITS:0]   cy_up;
  logic [DIGITS:0]   cy_dn;
  logic [4*DIGITS-1:0] nxt;
  logic [4*DIGITS-1:0] ld;
  logic [DIGITS-1:0] zero_hi;
  logic [DIGITS-1:0] blank;
  logic [DIGITS-1:0] an_nxt;
  logic [6:0]        cat_nxt;

  tick_gen #(.DIV(COUNT_DIV)) u_count_div (
    .clk  (clk),
    .rst  (rst),
    .tick (tick)
  );

  tick_gen #(.DIV(SCAN_DIV)) u_scan_div (
    .clk  (clk),
    .rst  (rst),
    .tick (scan_tick)
  );

  assign cy_up[0] = 1'b1;
  assign cy_dn[0] = 1'b1;

  // cy_up[k]/cy_dn[k]: all digits below k are 9/0
  for (genvar k = 0; k < DIGITS; k++) begin : g_dig
    logic [3:0] d;
    logic [3:0] d_inc;
    logic [3:0] d_dec;
    assign d     = count[4*k +: 4];
    assign d_inc = (d == 4'd9) ? 4'd0 : d + 4'd1;
    assign d_dec = (d == 4'd0) ? 4'd9 : d - 4'd1;
    assign cy_up[k+1] = cy_up[k] & (d == 4'd9);
    assign cy_dn[k+1] = cy_dn[k] & (d == 4'd0);
    assign nxt[4*k +: 4] =
      up ? (cy_up[k] ? d_inc : d)
         : (cy_dn[k] ? d_dec : d);
    assign ld[4*k +: 4] = bcd_clamp(load_val[4*k +: 4]);
    if (k == DIGITS - 1) begin : g_top
      assign zero_hi[k] = (d == 4'd0);
    end else begin : g_mid
      assign zero_hi[k] = (d == 4'd0) & zero_hi[k+1];
    end
    if (k == 0) begin : g_lsd
      assign blank[k] = 1'b0;
    end else begin : g_hsd
      assign blank[k] = blank_lz & zero_hi[k];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
      wrap  <= 1'b0;
    end else if (load) begin
      count <= ld;
      wrap  <= 1'b0;
    end else if (tick & en) begin
      count <= nxt;
      wrap  <= up ? cy_up[DIGITS] : cy_dn[DIGITS];
    end else begin
      wrap  <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst)
      idx <= '0;
    else if (scan_tick)
      idx <= (idx == IW'(DIGITS - 1)) ? '0 : idx + 1'b1;
  end

  always_comb begin
    an_nxt      = '1;
    an_nxt[idx] = 1'b0;
    cat_nxt     = blank[idx] ? SEG_BLANK
                             : seg_encode(count[4*idx +: 4]);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      seg_an  <= '1;
      seg_cat <= SEG_BLANK;
    end else begin
      seg_an  <= an_nxt;
      seg_cat <= cat_nxt;
    end
  end

endmodule

// File: tb/tb_bcd_display_counter.sv
// Directed bench for bcd_display_counter with an
// expected-value queue popped as the DUT responds.
module tb_bcd_display_counter;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic        up;
  logic        load;
  logic [15:0] load_val;
  logic        blank_lz;
  logic [15:0] count;
  logic        wrap;
  logic        tick;
  logic [6:0]  seg_cat;
  logic [3:0]  seg_an;

  typedef struct {
    string       tag;
    logic [31:0] val;
  } exp_t;

  exp_t sb[$];
  int   n_assert = 0;
  int   n_fail   = 0;

  bcd_display_counter #(
    .DIGITS   (4),
    .CLK_HZ   (1000),
    .COUNT_HZ (100),
    .SCAN_HZ  (50)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .up       (up),
    .load     (load),
    .load_val (load_val),
    .blank_lz (blank_lz),
    .count    (count),
    .wrap     (wrap),
    .tick     (tick),
    .seg_cat  (seg_cat),
    .seg_an   (seg_an)
  );

  always #5 clk = ~clk;

  task automatic push(input string t, input logic [31:0] v);
    exp_t e;
    e.tag = t;
    e.val = v;
    sb.push_back(e);
  endtask

  task automatic check(input logic [31:0] obs);
    exp_t e;
    n_assert++;
    if (sb.size() == 0) begin
      n_fail++;
      $error("FAIL sb_empty observed=%0h", obs);
    end else begin
      e = sb.pop_front();
      assert (obs === e.val) else begin
        n_fail++;
        $error("FAIL %s observed=%0h expected=%0h",
               e.tag, obs, e.val);
      end
    end
  endtask

  // Returns at the negedge after the tick edge, so the
  // counter update is already visible.
  task automatic wait_tick(output int n);
    n = 0;
    while (tick !== 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (tick !== 1'b1) begin
      push("tick_timeout", 1);
      check({31'd0, tick});
    end
    @(negedge clk);
  endtask

  logic [6:0] cat [4];
  int         n;
  int         k0;
  int         ticks;
  int         wraps;

  task automatic scan_collect(input string t);
    for (int k = 0; k < 4; k++) cat[k] = 'x;
    for (int j = 0; j < 20; j++) begin
      @(negedge clk);
      push($sformatf("%s_one_anode", t), 1);
      check($countones(~seg_an));
      for (int k = 0; k < 4; k++)
        if (seg_an[k] == 1'b0) cat[k] = seg_cat;
    end
  endtask

  initial begin
    rst = 1'b1; en = 1'b1; up = 1'b1; load = 1'b0;
    load_val = '0; blank_lz = 1'b0;
    repeat (3) @(negedge clk);

    push("rst_count", 0);      check(count);
    push("rst_wrap", 0);       check(wrap);
    push("rst_tick", 0);       check(tick);
    push("rst_seg_an", 4'hF);  check(seg_an);
    push("rst_seg_cat", 7'h7F); check(seg_cat);

    rst = 1'b0;
    push("first_tick_cycle", 9);
    wait_tick(n);
    check(n);
    push("count_after_1", 16'h0001); check(count);
    push("wrap_idle", 0);            check(wrap);
    push("tick_spacing", 10);
    wait_tick(n);
    check(n + 1);
    for (int i = 0; i < 8; i++) wait_tick(n);
    push("count_after_10", 16'h0010); check(count);

    load = 1'b1; load_val = 16'h9999;
    @(negedge clk);
    load = 1'b0;
    push("load_9999", 16'h9999); check(count);
    wait_tick(n);
    push("up_wrap_count", 16'h0000); check(count);
    push("up_wrap_pulse", 1);        check(wrap);
    @(negedge clk);
    push("up_wrap_one_cycle", 0);    check(wrap);
    up = 1'b0;
    wait_tick(n);
    push("dn_wrap_count", 16'h9999); check(count);
    push("dn_wrap_pulse", 1);        check(wrap);
    @(negedge clk);
    push("dn_wrap_one_cycle", 0);    check(wrap);

    load = 1'b1; load_val = 16'h12F4;
    @(negedge clk);
    load = 1'b0;
    push("load_clamp", 16'h1204); check(count);

    up = 1'b1;
    n = 0;
    while (tick !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    push("tick_for_load", 1); check({31'd0, tick});
    load = 1'b1; load_val = 16'h0042;
    @(negedge clk);
    load = 1'b0;
    push("load_over_tick", 16'h0042); check(count);
    @(negedge clk);
    push("load_held", 16'h0042); check(count);

    en = 1'b0;
    ticks = 0;
    wraps = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (tick) ticks++;
      if (wrap) wraps++;
    end
    push("en0_ticks", 5);         check(ticks);
    push("en0_wraps", 0);         check(wraps);
    push("en0_count", 16'h0042);  check(count);

    load = 1'b1; load_val = 16'h0007; blank_lz = 1'b1;
    @(negedge clk);
    load = 1'b0;
    repeat (2) @(negedge clk);
    scan_collect("blank");
    push("blank_d0", 7'b1111000); check(cat[0]);
    push("blank_d1", 7'b1111111); check(cat[1]);
    push("blank_d2", 7'b1111111); check(cat[2]);
    push("blank_d3", 7'b1111111); check(cat[3]);

    blank_lz = 1'b0;
    repeat (2) @(negedge clk);
    scan_collect("noblank");
    push("noblank_d0", 7'b1111000); check(cat[0]);
    push("noblank_d1", 7'b1000000); check(cat[1]);
    push("noblank_d2", 7'b1000000); check(cat[2]);
    push("noblank_d3", 7'b1000000); check(cat[3]);

    n = 0;
    begin
      logic [3:0] prev;
      prev = seg_an;
      @(negedge clk);
      while (seg_an === prev && n < 10) begin
        prev = seg_an;
        @(negedge clk);
        n++;
      end
    end
    push("scan_change_seen", 1); check({31'd0, n < 10});
    k0 = 0;
    for (int k = 0; k < 4; k++)
      if (seg_an[k] == 1'b0) k0 = k;
    for (int j = 0; j < 20; j++) begin
      push($sformatf("scan_an_%0d", j),
           {28'd0, ~(4'b0001 << ((k0 + j / 5) % 4))});
      check(seg_an);
      @(negedge clk);
    end

    en = 1'b1; up = 1'b1;
    repeat (13) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    push("mid_rst_count", 0);       check(count);
    push("mid_rst_wrap", 0);        check(wrap);
    push("mid_rst_tick", 0);        check(tick);
    push("mid_rst_seg_an", 4'hF);   check(seg_an);
    push("mid_rst_seg_cat", 7'h7F); check(seg_cat);
    rst = 1'b0;
    push("post_rst_tick_cycle", 9);
    wait_tick(n);
    check(n);
    push("post_rst_count", 16'h0001); check(count);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/bcd_display_counter.md
# bcd_display_counter

Parametrised multi-digit BCD up/down counter with a built-in rate prescaler, parallel load and wrap flag. It drives a time-multiplexed, active-low common-anode 7-segment display with optional leading-zero blanking. It sits between the board clock and the display pins and supersedes the single-digit counter, decoder and fixed-rate divider set.

## Interface
- DIGITS, 4: number of BCD digits, 1..8; also the number of anodes.
- CLK_HZ, 100_000_000: input clock frequency.
- COUNT_HZ, 1: count tick rate. COUNT_DIV = CLK_HZ/COUNT_HZ, must be ≥1.
- SCAN_HZ, 1000: full-display refresh rate. SCAN_DIV = CLK_HZ/(SCAN_HZ*DIGITS), must be ≥1.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset, synchronous, active-high.
- en  in  1  count enable, sampled on count tick.
- up  in  1  direction: 1 = increment, 0 = decrement.
- load  in  1  parallel load strobe.
- load_val  in  4*DIGITS  BCD load value; digit 0 is in [3:0].
- blank_lz  in  1  1 = blank leading zeros.
- count  out  4*DIGITS  registered BCD count.
- wrap  out  1  one-cycle pulse on 9..9→0..0 (up) or 0..0→9..9 (down).
- tick  out  1  one-cycle count-tick pulse, for debug and chaining.
- seg_cat  out  7  cathodes {g,f,e,d,c,b,a}, active-low.
- seg_an  out  DIGITS  anodes, active-low, at most one low.

## Operation
- Count prescaler: a free-running counter 0..COUNT_DIV-1, width $clog2(COUNT_DIV) (min 1). `tick` is high when it equals COUNT_DIV-1, which is also the cycle it clears. It runs regardless of en, load or up.
- Counter update priority, per clock edge:
  1. rst
  2. load
  3. tick&en
  4. hold
- Load: count ← load_val. Any digit >9 is loaded as 0. A tick in the same cycle is dropped. wrap stays 0.
- Up: digit 0 increments. Digit k increments only when digits 0..k-1 are all 9. A digit at 9 rolls to 0. All-9 → all-0 with wrap=1.
- Down: mirror of up. A digit at 0 rolls to 9, and digit k decrements only when lower digits are all 0. All-0 → all-9 with wrap=1.
- Scan: a second prescaler (SCAN_DIV) advances digit index 0..DIGITS-1, wrapping to 0.
- Display decode per index: 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000.
- Leading-zero blanking: when blank_lz=1, a digit k>0 is blanked (seg_cat=1111111) if it and all higher digits are 0. Digit 0 is never blanked.
- seg_an: bit[index]=0, all other bits 1.

## Timing
- Reset: count=0, wrap=0, both prescalers=0, tick=0, index=0, seg_an=all 1, seg_cat=1111111.
- Count and wrap are registered and change on the edge where tick&en (or load) is high. They are visible the following cycle. wrap is high for exactly that one cycle.
- Ticks are spaced exactly COUNT_DIV cycles. The first tick is COUNT_DIV-1 cycles after reset release.
- seg_an and seg_cat are registered from the current index and count, one cycle of latency. The display reflects a count change one cycle after count changes.
- Each digit is lit for SCAN_DIV consecutive cycles.
- rst mid-operation overrides everything in the same edge. No partial state survives.
- `up` may change at any time. It is sampled only on a tick.

## Structure
- Package bcd_disp_pkg:
  - SEG_BLANK constant.
  - Function seg_encode(logic [3:0]) → [6:0]; codes >9 return SEG_BLANK.
  - Function bcd_clamp(logic [3:0]) → [3:0].
- Sub-module tick_gen, parameter DIV, ports clk/rst/tick. It is instantiated twice, for the count and scan prescalers.
- The digit chain is a generate loop over DIGITS.

## Test plan
Sim parameters: CLK_HZ=1000, COUNT_HZ=100 (COUNT_DIV=10), SCAN_HZ=50, DIGITS=4 (SCAN_DIV=5).
- Reset, en=1, up=1: tick first at cycle 9, then every 10 cycles. count=0x0001 after first tick, 0x0010 after 10 ticks.
- load_val=0x9999, up=1, one tick → count=0x0000, wrap high one cycle. Then up=0, one tick → 0x9999, wrap high.
- load_val=0x12F4 → count=0x1204. Assert load coincident with tick while en=1 → loaded value held, no increment.
- en=0 across 5 ticks → count unchanged, wrap=0. rst asserted mid-count → all outputs at reset values next cycle.
- count=0x0007, blank_lz=1 → digit 0 shows 1111000, digits 1-3 show 1111111. With blank_lz=0 → digits 1-3 show 1000000.
- Scan: seg_an sequence 1110,1101,1011,0111 repeats, each held 5 cycles. Never more than one anode low.
